// File: rtl/lcd_driver.sv
// RGB-LCD pixel transmitter: ID-selected timing, HS/VS/DE and pixel requests.
// Define LCD_TEST_PATTERN_EN to replace pixel_data with eight colour bars.
module lcd_driver (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] lcd_id,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_rgb_oe,
    output logic        lcd_bl,
    output logic        lcd_rst
);
    typedef enum logic [1:0] {IDLE, WAIT, RUN} state_e;

    state_e      state_q, state_d;
    logic [15:0] mode_q, mode_d;
    logic [9:0]  wcnt_q, wcnt_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] hs_w, hbp_w, hact_w, htot_w;
    logic [10:0] vs_w, vbp_w, vact_w, vtot_w;
    logic [10:0] h_start, v_start, h_ahead;
    logic        run_w, in_v, req_w;
    logic [23:0] pix_w;

    logic        hs_q, vs_q, req_q, dep_q, de_q;
    logic [10:0] xpos_q, ypos_q, hdisp_q, vdisp_q;
    logic [23:0] rgb_q;
    logic        oe_q, bl_q, rst_q;

    function automatic logic id_supported(input logic [15:0] id);
        return (id == 16'h4342) || (id == 16'h7084) || (id == 16'h4384) ||
               (id == 16'h7016) || (id == 16'h1018);
    endfunction

    always_comb begin
        hs_w = '0; hbp_w = '0; hact_w = '0; htot_w = '0;
        vs_w = '0; vbp_w = '0; vact_w = '0; vtot_w = '0;
        case (mode_q)
            16'h4342: begin
                hs_w = 11'd41;  hbp_w = 11'd2;  hact_w = 11'd480;  htot_w = 11'd525;
                vs_w = 11'd10;  vbp_w = 11'd2;  vact_w = 11'd272;  vtot_w = 11'd286;
            end
            16'h7084, 16'h4384: begin
                hs_w = 11'd128; hbp_w = 11'd88; hact_w = 11'd800;  htot_w = 11'd1056;
                vs_w = 11'd2;   vbp_w = 11'd33; vact_w = 11'd480;  vtot_w = 11'd525;
            end
            16'h7016: begin
                hs_w = 11'd20;  hbp_w = 11'd140; hact_w = 11'd1024; htot_w = 11'd1344;
                vs_w = 11'd3;   vbp_w = 11'd20;  vact_w = 11'd600;  vtot_w = 11'd635;
            end
            16'h1018: begin
                hs_w = 11'd10;  hbp_w = 11'd80; hact_w = 11'd1280; htot_w = 11'd1440;
                vs_w = 11'd3;   vbp_w = 11'd10; vact_w = 11'd800;  vtot_w = 11'd823;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wcnt_d  = '0;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (id_supported(lcd_id)) begin
                    state_d = WAIT;
                    mode_d  = lcd_id;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + 10'd1;
                if (wcnt_q == 10'd1023) state_d = RUN;
            end
            RUN: begin
                h_cnt_d = h_cnt_q + 11'd1;
                v_cnt_d = v_cnt_q;
                if (h_cnt_q == htot_w - 11'd1) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == vtot_w - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests run two counts ahead so DE lands on the window after the fetch.
    assign run_w   = (state_q == RUN);
    assign h_start = hs_w + hbp_w;
    assign v_start = vs_w + vbp_w;
    assign h_ahead = h_cnt_q + 11'd2;
    assign in_v    = (v_cnt_q >= v_start) && (v_cnt_q < v_start + vact_w);
    assign req_w   = run_w && in_v &&
                     (h_ahead >= h_start) && (h_ahead < h_start + hact_w);

`ifdef LCD_TEST_PATTERN_EN
    logic [10:0] bar_len_w, bcnt_q;
    logic [2:0]  bar_q;
    logic [23:0] col_q;

    function automatic logic [23:0] bar_colour(input logic [2:0] b);
        case (b)
            3'd0: return 24'hFFFFFF;
            3'd1: return 24'hFFFF00;
            3'd2: return 24'h00FFFF;
            3'd3: return 24'h00FF00;
            3'd4: return 24'hFF00FF;
            3'd5: return 24'hFF0000;
            3'd6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign bar_len_w = hact_w >> 3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !req_q) begin
            bcnt_q <= '0;
            bar_q  <= '0;
            col_q  <= '0;
        end else begin
            col_q <= bar_colour(bar_q);
            if (bcnt_q == bar_len_w - 11'd1) begin
                bcnt_q <= '0;
                bar_q  <= bar_q + 3'd1;
            end else begin
                bcnt_q <= bcnt_q + 11'd1;
            end
        end
    end

    assign pix_w = col_q;
`else
    assign pix_w = pixel_data;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            wcnt_q  <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            req_q   <= 1'b0;
            dep_q   <= 1'b0;
            de_q    <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            hdisp_q <= '0;
            vdisp_q <= '0;
            rgb_q   <= '0;
            oe_q    <= 1'b0;
            bl_q    <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wcnt_q  <= wcnt_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= !(run_w && (h_cnt_q < hs_w));
            vs_q    <= !(run_w && (v_cnt_q < vs_w));
            req_q   <= req_w;
            dep_q   <= req_q;
            de_q    <= dep_q;
            xpos_q  <= req_w ? h_ahead - h_start : 11'd0;
            ypos_q  <= req_w ? v_cnt_q - v_start : 11'd0;
            rgb_q   <= dep_q ? pix_w : 24'h0;
            hdisp_q <= (state_d == RUN) ? hact_w : 11'd0;
            vdisp_q <= (state_d == RUN) ? vact_w : 11'd0;
            oe_q    <= (state_d == RUN);
            bl_q    <= (state_d == RUN);
            rst_q   <= (state_d != IDLE);
        end
    end

    assign data_req   = req_q;
    assign pixel_xpos = xpos_q;
    assign pixel_ypos = ypos_q;
    assign h_disp     = hdisp_q;
    assign v_disp     = vdisp_q;
    assign lcd_hs     = hs_q;
    assign lcd_vs     = vs_q;
    assign lcd_de     = de_q;
    assign lcd_rgb    = rgb_q;
    assign lcd_rgb_oe = oe_q;
    assign lcd_bl     = bl_q;
    assign lcd_rst    = rst_q;
endmodule
